// File: rtl/surfturf_cmd_queue.sv
// surfturf_cmd_queue: NCHAN independent first-word-fall-through command FIFOs.
// Commands are pushed by Wishbone writes and drained through per-channel
// AXI4-Stream master ports. Everything runs on wb_clk_i. The reset is asserted
// asynchronously and released synchronously through a two-flop synchroniser.
module surfturf_cmd_queue #(
    parameter int NCHAN      = 2,
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [5:0]             wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic [31:0]            wb_dat_o,
    output logic [NCHAN*WIDTH-1:0] cmd_tdata,
    output logic [NCHAN-1:0]       cmd_tvalid,
    input  logic [NCHAN-1:0]       cmd_tready
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CW     = DEPTH_LOG2 + 1;
    localparam int NBYTES = (WIDTH + 7) / 8;
    // Byte lanes that must all be selected for a data push to be accepted
    localparam logic [3:0]    SEL_NEED = 4'((32'd1 << NBYTES) - 32'd1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [1:0]             rst_sync_q;
    logic                   rst_n_s;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d;
    logic [NCHAN-1:0]       ovf_q, ovf_d;
    logic [CW-1:0]          count_q  [NCHAN];
    logic [CW-1:0]          count_d  [NCHAN];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q [NCHAN];
    logic [DEPTH_LOG2-1:0]  wr_ptr_d [NCHAN];
    logic [DEPTH_LOG2-1:0]  rd_ptr_q [NCHAN];
    logic [DEPTH_LOG2-1:0]  rd_ptr_d [NCHAN];
    logic [WIDTH-1:0]       mem_q    [NCHAN][DEPTH];
    logic [NCHAN-1:0]       push_s, pop_s, flush_s, clr_s, we_s, ovf_set_s;
    logic [NCHAN-1:0]       empty_s, full_s;
    logic                   wr_acc_s, ctrl_wr_s;
    logic                   unused_s;

    assign unused_s = ^{wb_adr_i[1:0], wb_dat_i};
    assign rst_n_s  = rst_sync_q[1];

    // Reset synchroniser: asserts immediately, releases on a clock edge
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    // Access decode: write side effects only on the ack cycle of a write
    always_comb begin
        wr_acc_s  = wb_cyc_i & wb_stb_i & wb_we_i & ack_q;
        ctrl_wr_s = wr_acc_s & (wb_adr_i[5:2] == 4'h0);
        push_s    = '0;
        flush_s   = '0;
        clr_s     = '0;
        empty_s   = '0;
        full_s    = '0;
        pop_s     = '0;
        for (int n = 0; n < NCHAN; n++) begin
            push_s[n]  = wr_acc_s & wb_adr_i[5] & (wb_adr_i[4:2] == 3'(n))
                         & ((wb_sel_i & SEL_NEED) == SEL_NEED);
            flush_s[n] = ctrl_wr_s & wb_sel_i[0] & wb_dat_i[n];
            clr_s[n]   = ctrl_wr_s & wb_sel_i[2] & wb_dat_i[16+n];
            empty_s[n] = (count_q[n] == {CW{1'b0}});
            full_s[n]  = (count_q[n] == DEPTH_C);
            pop_s[n]   = ~empty_s[n] & cmd_tready[n];
        end
    end

    // FIFO next state; fullness is judged before the same-cycle pop, flush wins
    always_comb begin
        we_s      = '0;
        ovf_set_s = '0;
        for (int n = 0; n < NCHAN; n++) begin
            count_d[n]  = count_q[n];
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            if (flush_s[n]) begin
                count_d[n]  = {CW{1'b0}};
                wr_ptr_d[n] = {DEPTH_LOG2{1'b0}};
                rd_ptr_d[n] = {DEPTH_LOG2{1'b0}};
            end else begin
                we_s[n]      = push_s[n] & ~full_s[n];
                ovf_set_s[n] = push_s[n] & full_s[n];
                wr_ptr_d[n]  = wr_ptr_q[n] + DEPTH_LOG2'(we_s[n]);
                rd_ptr_d[n]  = rd_ptr_q[n] + DEPTH_LOG2'(pop_s[n]);
                count_d[n]   = count_q[n] + CW'(we_s[n]) - CW'(pop_s[n]);
            end
        end
        // A new overflow in the same cycle as its clear keeps the flag set
        ovf_d = (ovf_q & ~clr_s) | ovf_set_s;
    end

    // Wishbone ack and registered read data
    always_comb begin
        ack_d = wb_cyc_i & wb_stb_i;
        dat_d = 32'h0000_0000;
        if (wb_cyc_i & wb_stb_i & ~wb_we_i) begin
            case (wb_adr_i[5:2])
                4'h0: dat_d[16 +: NCHAN] = ovf_q;
                4'h1: begin
                    dat_d[0 +: NCHAN]  = empty_s;
                    dat_d[16 +: NCHAN] = full_s;
                end
                default: begin
                    for (int n = 0; n < NCHAN; n++) begin
                        dat_d[CW-1:0] = dat_d[CW-1:0] |
                            ((wb_adr_i[5] && (wb_adr_i[4:2] == 3'(n))) ? count_q[n] : {CW{1'b0}});
                    end
                end
            endcase
        end else begin
            dat_d = 32'h0000_0000;
        end
    end

    // State registers
    always_ff @(posedge wb_clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0000_0000;
            ovf_q <= '0;
            for (int n = 0; n < NCHAN; n++) begin
                count_q[n]  <= {CW{1'b0}};
                wr_ptr_q[n] <= {DEPTH_LOG2{1'b0}};
                rd_ptr_q[n] <= {DEPTH_LOG2{1'b0}};
            end
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            for (int n = 0; n < NCHAN; n++) begin
                count_q[n]  <= count_d[n];
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
            end
        end
    end

    // Command storage, written only on accepted pushes
    always_ff @(posedge wb_clk_i) begin
        for (int n = 0; n < NCHAN; n++) begin
            if (we_s[n]) begin
                mem_q[n][wr_ptr_q[n]] <= wb_dat_i[WIDTH-1:0];
            end
        end
    end

    // Stream outputs: head entry while non-empty, zero otherwise
    always_comb begin
        cmd_tdata  = '0;
        cmd_tvalid = ~empty_s;
        for (int n = 0; n < NCHAN; n++) begin
            cmd_tdata[n*WIDTH +: WIDTH] = empty_s[n] ? {WIDTH{1'b0}} : mem_q[n][rd_ptr_q[n]];
        end
    end

    assign wb_ack_o = ack_q & wb_cyc_i;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_surfturf_cmd_queue.sv
// Bench for surfturf_cmd_queue: directed scenarios plus a random phase, all
// checked by a monitor against a queue-based model of the command channels.
module tb_surfturf_cmd_queue;

    localparam int NCH   = 2;
    localparam int W     = 16;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [5:0]        adr;
    logic [31:0]       dat;
    logic [3:0]        sel;
    logic              ack_o, err_o, rty_o;
    logic [31:0]       dat_o;
    logic [NCH*W-1:0]  tdata;
    logic [NCH-1:0]    tvalid;
    logic [NCH-1:0]    tready;

    always #5 clk = ~clk;

    surfturf_cmd_queue #(.NCHAN(NCH), .WIDTH(W), .DEPTH_LOG2(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat),
        .wb_sel_i   (sel),
        .wb_ack_o   (ack_o),
        .wb_err_o   (err_o),
        .wb_rty_o   (rty_o),
        .wb_dat_o   (dat_o),
        .cmd_tdata  (tdata),
        .cmd_tvalid (tvalid),
        .cmd_tready (tready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_mode = 1'b0;

    // Reference model: one queue of pending commands per channel plus overflow flags
    logic [W-1:0]   mq [NCH][$];
    logic [NCH-1:0] movf = '0;
    logic [31:0]    prev_exp = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register value the model predicts for a read of address a
    function automatic logic [31:0] exp_rd(input logic [5:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a[5:2])
            4'h0: r[16 +: NCH] = movf;
            4'h1: for (int n = 0; n < NCH; n++) begin
                r[n]    = (mq[n].size() == 0);
                r[16+n] = (mq[n].size() == DEPTH);
            end
            default: for (int n = 0; n < NCH; n++) begin
                if (a[5] && a[4:2] == 3'(n)) r = 32'(mq[n].size());
            end
        endcase
        return r;
    endfunction

    // Monitor: compares stream outputs and read data, then advances the model
    always @(negedge clk) begin : monitor
        logic [NCH-1:0] fl, cl, pu, st;
        logic [31:0]    cur_exp;
        logic           wr, rd, was_full, pop;
        if (!rst_n) begin
            for (int n = 0; n < NCH; n++) mq[n].delete();
            movf     = '0;
            prev_exp = 32'h0;
        end else begin
            cur_exp = exp_rd(adr);
            for (int n = 0; n < NCH; n++) begin
                chk($sformatf("tvalid%0d", n), 32'(tvalid[n]), 32'(mq[n].size() != 0));
                if (mq[n].size() != 0)
                    chk($sformatf("tdata%0d", n), 32'(tdata[n*W +: W]), 32'(mq[n][0]));
            end
            wr = cyc & stb & we & ack_o;
            rd = cyc & stb & ~we & ack_o;
            if (rd) chk($sformatf("wb_read@%02h", adr), dat_o, prev_exp);
            fl = '0; cl = '0; pu = '0; st = '0;
            if (wr && adr[5:2] == 4'h0) begin
                if (sel[0]) fl = dat[NCH-1:0];
                if (sel[2]) cl = dat[16 +: NCH];
            end
            if (wr && adr[5] && sel[1:0] == 2'b11)
                for (int n = 0; n < NCH; n++) if (adr[4:2] == 3'(n)) pu[n] = 1'b1;
            for (int n = 0; n < NCH; n++) begin
                was_full = (mq[n].size() == DEPTH);
                pop      = (mq[n].size() != 0) && tready[n];
                if (fl[n]) begin
                    mq[n].delete();
                end else begin
                    if (pop) void'(mq[n].pop_front());
                    if (pu[n]) begin
                        if (was_full) st[n] = 1'b1;
                        else mq[n].push_back(dat[W-1:0]);
                    end
                end
            end
            movf     = (movf & ~cl) | st;
            prev_exp = cur_exp;
        end
    end

    task automatic wb_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [NCH-1:0] rdy_ack);
        bit got;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
        @(posedge clk); #1;
        tready = tready | rdy_ack;
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_o) begin got = 1'b1; break; end
        end
        chk("wb_write_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tready = tready & ~rdy_ack;
    endtask

    task automatic wb_read(input logic [5:0] a, output logic [31:0] d);
        bit got;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        got = 1'b0;
        d   = 32'hx;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack_o) begin got = 1'b1; d = dat_o; break; end
        end
        chk("wb_read_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    // Random ready pattern during the random phase
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_mode) tready = NCH'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          r, ch;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = 6'h0; dat = 32'h0; sel = 4'h0; tready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'h0);
        chk("rst_tdata", 32'(tdata), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        wb_read(6'h04, d); chk("status_reset", d, 32'h0000_0003);
        wb_read(6'h20, d); chk("level0_reset", d, 32'h0);

        // Two pushes, then drain with ready held two cycles
        wb_write(6'h20, 32'h0000_1234, 4'hF, 2'b00);
        wb_write(6'h20, 32'h0000_5678, 4'hF, 2'b00);
        @(negedge clk);
        chk("tvalid0_after_push", 32'(tvalid[0]), 32'd1);
        chk("tdata0_head", 32'(tdata[15:0]), 32'h1234);
        wb_read(6'h20, d); chk("level0_two", d, 32'd2);
        @(posedge clk); #1 tready[0] = 1'b1;
        @(negedge clk); chk("pop_first", 32'(tdata[15:0]), 32'h1234);
        @(negedge clk); chk("pop_second", 32'(tdata[15:0]), 32'h5678);
        @(posedge clk); #1 tready[0] = 1'b0;
        @(negedge clk); chk("ch0_empty", 32'(tvalid[0]), 32'd0);

        // Overfill channel 1
        for (int i = 0; i < 17; i++) wb_write(6'h24, 32'h100 + 32'(i), 4'hF, 2'b00);
        wb_read(6'h24, d); chk("level1_full", d, 32'd16);
        wb_read(6'h04, d); chk("status_full1", d, 32'h0002_0001);
        wb_read(6'h00, d); chk("ovf1_set", d, 32'h0002_0000);
        wb_write(6'h00, 32'h0002_0000, 4'b0100, 2'b00);
        wb_read(6'h00, d); chk("ovf1_cleared", d, 32'h0);

        // Full channel 0 with a pop on the push ack cycle
        for (int i = 0; i < 16; i++) wb_write(6'h20, 32'h200 + 32'(i), 4'hF, 2'b00);
        wb_write(6'h20, 32'h0000_DEAD, 4'hF, 2'b01);
        wb_read(6'h20, d); chk("level0_full_pop", d, 32'd15);
        wb_read(6'h00, d); chk("ovf0_set", d, 32'h0001_0000);

        // Flush channel 0 on the same cycle as a pop
        wb_write(6'h00, 32'h0000_0001, 4'b0001, 2'b01);
        wb_read(6'h20, d); chk("level0_flushed", d, 32'd0);
        @(negedge clk); chk("tvalid0_flushed", 32'(tvalid[0]), 32'd0);
        wb_read(6'h00, d); chk("ovf_after_flush", d, 32'h0001_0000);
        wb_read(6'h24, d); chk("level1_untouched", d, 32'd16);

        // Drain channel 1; the dropped 17th value must not appear
        @(posedge clk); #1 tready[1] = 1'b1;
        repeat (20) @(posedge clk);
        #1 tready[1] = 1'b0;
        @(negedge clk); chk("ch1_drained", 32'(tvalid[1]), 32'd0);

        // Partial byte select is ignored; reset drops queued data
        wb_write(6'h20, 32'h0000_BEEF, 4'b0001, 2'b00);
        wb_read(6'h20, d); chk("partial_sel_ignored", d, 32'd0);
        for (int i = 0; i < 3; i++) wb_write(6'h20, 32'h300 + 32'(i), 4'hF, 2'b00);
        wb_read(6'h20, d); chk("level0_three", d, 32'd3);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("rst_async_tvalid", 32'(tvalid), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        wb_read(6'h20, d); chk("level0_after_rst", d, 32'd0);
        wb_read(6'h00, d); chk("ovf_after_rst", d, 32'h0);

        // Random traffic checked by the monitor
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            ch = $urandom_range(0, NCH - 1);
            if (r <= 5)
                wb_write(6'h20 + 6'(4 * ch), $urandom,
                         ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF, 2'b00);
            else if (r == 6)
                wb_write(6'h00, $urandom & 32'h0000_0003, 4'b0001, 2'b00);
            else if (r == 7)
                wb_write(6'h00, $urandom & 32'h0003_0003, 4'($urandom), 2'b00);
            else
                wb_read(6'($urandom_range(0, 15) * 4), d);
        end
        rnd_mode = 1'b0;
        @(posedge clk); #2 tready = '1;
        repeat (40) @(posedge clk);
        wb_read(6'h04, d); chk("status_drained", d, 32'h0000_0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
